integral_ctrl: RTL and testbench

INTEGRAL_CTRL -- requirements
Module: integral_ctrl

---
 rtl/integral_ctrl_pkg.sv | 28 ++
 rtl/integral_ctrl_sat_adder.sv | 43 ++++
 rtl/integral_ctrl.sv | 142 ++++++++++++++
 tb/tb_integral_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_ctrl_pkg.sv
// Shared definitions for the integral controller.
//   state_e      : controller state encoding
//   DEF_*        : default widths / multiply latency
//   SAT_MAX/MIN  : clamp limits of the integral at the default ACC_W
//   prod_width() : width of the signed err x unsigned dt product
package integral_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_ADD  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_DT_W     = 4;
   localparam int DEF_ACC_W    = 16;
   localparam int DEF_MULT_LAT = 2;

   localparam int SAT_MAX = (2 ** (DEF_ACC_W - 1)) - 1;
   localparam int SAT_MIN = -(2 ** (DEF_ACC_W - 1));

   // dt is treated as unsigned, so one extra bit keeps the product signed.
   function automatic int prod_width(input int data_w, input int dt_w);
      return data_w + dt_w + 1;
   endfunction

endpackage

// File: rtl/integral_ctrl_sat_adder.sv
// Combinational accumulate-and-clamp.
//   acc_i  : current signed integral (ACC_W)
//   prod_i : signed product to add (PROD_W)
//   sum_o  : acc_i + prod_i clamped to the signed ACC_W range
//   sat_o  : 1 when sum_o was clamped
module sat_adder #(
   parameter int ACC_W  = 16,
   parameter int PROD_W = 13
) (
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic signed [PROD_W-1:0] prod_i,
   output logic signed [ACC_W-1:0]  sum_o,
   output logic                     sat_o
);

   // One guard bit above the wider operand so the raw sum never wraps.
   localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

   logic signed [SUM_W-1:0] acc_x;
   logic signed [SUM_W-1:0] prod_x;
   logic signed [SUM_W-1:0] sum_x;
   logic [SUM_W-ACC_W:0]    top_bits;
   logic                    ovf;

   assign acc_x  = {{(SUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
   assign prod_x = {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
   assign sum_x  = acc_x + prod_x;

   // The sum fits in ACC_W bits only if every bit from the ACC_W sign bit
   // upward agrees.
   assign top_bits = sum_x[SUM_W-1:ACC_W-1];
   assign ovf      = !((&top_bits) | ~(|top_bits));

   always_comb begin
      sum_o = sum_x[ACC_W-1:0];
      sat_o = ovf;
      if (ovf) begin
         sum_o = sum_x[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/integral_ctrl.sv
// Sampled integrator: integral += err * dt, saturating.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : sample handshake (err, dt captured on acceptance)
//   clr                 : synchronous clear, aborts any sample in flight
//   hold                : blocks acceptance of new samples only
//   integral            : signed accumulated value
//   out_valid / sat     : one-cycle completion pulse, clamp flag with it
//   busy                : controller not idle
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a sample, in_ready may be high
// MULT    | product registered; counter paces MULT_LAT cycles
// ADD     | clamped sum written to the integral
// DONE    | raise out_valid (and sat) on the exit edge
module integral_ctrl
   import integral_ctrl_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DT_W     = DEF_DT_W,
   parameter int ACC_W    = DEF_ACC_W,
   parameter int MULT_LAT = DEF_MULT_LAT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] err,
   input  logic [DT_W-1:0]          dt,
   input  logic                     clr,
   input  logic                     hold,
   output logic signed [ACC_W-1:0]  integral,
   output logic                     out_valid,
   output logic                     sat,
   output logic                     busy
);

   localparam int PROD_W = prod_width(DATA_W, DT_W);
   localparam int CNT_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [DATA_W-1:0]  err_q;
   logic [DT_W-1:0]           dt_q;
   logic signed [PROD_W-1:0]  prod_q;
   logic signed [ACC_W-1:0]   integral_q;
   logic                      sat_pend_q;
   logic                      out_valid_q;
   logic                      sat_q;
   logic                      busy_q;

   logic signed [PROD_W-1:0]  err_x;
   logic signed [PROD_W-1:0]  dt_x;
   logic signed [PROD_W-1:0]  prod_d;
   logic signed [ACC_W-1:0]   integral_d;
   logic                      sat_d;

   assign err_x  = {{(DT_W+1){err_q[DATA_W-1]}}, err_q};
   assign dt_x   = {{DATA_W{1'b0}}, 1'b0, dt_q};
   assign prod_d = err_x * dt_x;

   sat_adder #(
      .ACC_W  (ACC_W),
      .PROD_W (PROD_W)
   ) u_sat_adder (
      .acc_i  (integral_q),
      .prod_i (prod_q),
      .sum_o  (integral_d),
      .sat_o  (sat_d)
   );

   // Gated by rst_n so nothing looks acceptable while reset is held.
   assign in_ready = rst_n & (state_q == ST_IDLE) & ~hold & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         err_q       <= '0;
         dt_q        <= '0;
         prod_q      <= '0;
         integral_q  <= '0;
         sat_pend_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else if (clr) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         integral_q  <= '0;
         sat_pend_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  err_q   <= err;
                  dt_q    <= dt;
                  cnt_q   <= CNT_W'(MULT_LAT - 1);
                  state_q <= ST_MULT;
                  busy_q  <= 1'b1;
               end
            end
            ST_MULT: begin
               prod_q <= prod_d;
               if (cnt_q == '0) begin
                  state_q <= ST_ADD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_ADD: begin
               integral_q <= integral_d;
               sat_pend_q <= sat_d;
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               // The pulse lands on the exit edge, giving MULT_LAT+2 latency.
               out_valid_q <= 1'b1;
               sat_q       <= sat_pend_q;
               sat_pend_q  <= 1'b0;
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign integral  = integral_q;
   assign out_valid = out_valid_q;
   assign sat       = sat_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_integral_ctrl.sv
module tb_integral_ctrl;
   import integral_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] err = '0;
   logic [3:0]        dt = '0;
   logic              clr = 1'b0;
   logic              hold = 1'b0;
   logic signed [15:0] integral;
   logic              out_valid;
   logic              sat;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;
   int model_acc = 0;

   integral_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .err       (err),
      .dt        (dt),
      .clr       (clr),
      .hold      (hold),
      .integral  (integral),
      .out_valid (out_valid),
      .sat       (sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One full sample: offer, wait for the result, compare with the model.
   task automatic send(input int e, input int d, input bit hold_after);
      int     w;
      int     lat;
      longint s;
      bit     exp_sat;
      w = 0;
      err = e[7:0];
      dt = d[3:0];
      in_valid = 1'b1;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      err = 8'($urandom);
      dt = 4'($urandom);
      if (hold_after) hold = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            chk("busy_inflight", longint'(busy), 1);
            chk("sat_idle", longint'(sat), 0);
         end
      end while (!out_valid && lat < 12);
      s = longint'(model_acc) + longint'(e) * longint'(d);
      exp_sat = 1'b0;
      if (s > SAT_MAX) begin s = SAT_MAX; exp_sat = 1'b1; end
      if (s < SAT_MIN) begin s = SAT_MIN; exp_sat = 1'b1; end
      model_acc = int'(s);
      chk("latency", lat, 4);
      chk("integral", longint'(integral), s);
      chk("sat", longint'(sat), longint'(exp_sat));
      @(posedge clk);
      #1;
      chk("pulse_len", longint'(out_valid), 0);
      chk("sat_after", longint'(sat), 0);
      hold = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("clr_blocks_ready", longint'(in_ready), 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      in_valid = 1'b0;
      model_acc = 0;
      chk("clr_integral", longint'(integral), 0);
      chk("clr_busy", longint'(busy), 0);
      @(posedge clk);
      #1;
      chk("clr_not_accepted", longint'(busy), 0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int d;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_integral", longint'(integral), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_sat", longint'(sat), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      rst_n = 1'b1;

      // basic accumulation
      send(5, 3, 1'b0);
      send(-20, 2, 1'b0);
      chk("basic_model", longint'(model_acc), -25);

      // positive saturation
      do_clr();
      for (int i = 0; i < 17; i++) send(127, 15, 1'b0);
      chk("pos_17th", longint'(integral), 32385);
      send(127, 15, 1'b0);
      chk("pos_clamp", longint'(integral), 32767);

      // negative saturation
      do_clr();
      for (int i = 0; i < 17; i++) send(-128, 15, 1'b0);
      chk("neg_17th", longint'(integral), -32640);
      send(-128, 15, 1'b0);
      chk("neg_clamp", longint'(integral), -32768);

      // zero operands leave the integral alone
      send(0, 9, 1'b0);
      send(77, 0, 1'b0);

      // clr during MULT discards the sample
      do_clr();
      send(100, 1, 1'b0);
      err = 8'sd50;
      dt = 4'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_acc = 0;
      chk("clr_mult_integral", longint'(integral), 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("clr_mult_no_pulse", longint'(out_valid), 0);
      end
      send(2, 1, 1'b0);
      chk("after_clr_model", longint'(model_acc), 2);

      // hold blocks acceptance
      hold = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         err = 8'($urandom);
         dt = 4'($urandom);
         @(posedge clk);
         #1;
         chk("hold_ready", longint'(in_ready), 0);
         chk("hold_busy", longint'(busy), 0);
      end
      hold = 1'b0;
      send(-7, 5, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         e = int'($urandom_range(255)) - 128;
         d = int'($urandom_range(15));
         if ($urandom_range(7) == 0) e = 0;
         if ($urandom_range(7) == 0) d = 0;
         if ($urandom_range(9) == 0) do_clr();
         if ($urandom_range(3) == 0) begin
            hold = 1'b1;
            in_valid = 1'b1;
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
               chk("rand_hold_ready", longint'(in_ready), 0);
            end
            hold = 1'b0;
         end
         send(e, d, 1'(($urandom_range(2) == 0)));
      end

      // reset during ADD abandons the sample immediately
      send(50, 2, 1'b0);
      err = 8'sd40;
      dt = 4'd4;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      model_acc = 0;
      chk("arst_integral", longint'(integral), 0);
      chk("arst_out_valid", longint'(out_valid), 0);
      chk("arst_busy", longint'(busy), 0);
      chk("arst_in_ready", longint'(in_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("arst_no_pulse", longint'(out_valid), 0);
      end
      send(3, 3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
